// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, opcode
// constants, instruction-register field positions and small helpers.
package cpu_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        WAIT_MEM  = 4'd2,
        LOAD_IR   = 4'd3,
        DECODE    = 4'd4,
        START     = 4'd5,
        EXEC_ACK  = 4'd6,
        EXEC_DONE = 4'd7,
        RETIRE    = 4'd8,
        ADVANCE   = 4'd9
    } fetch_state_t;

    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int OPCODE_HI   = 15;
    localparam int OPCODE_LO   = 13;
    localparam int ALU_OP_HI   = 12;
    localparam int ALU_OP_LO   = 11;
    localparam int SHIFT_OP_HI = 4;
    localparam int SHIFT_OP_LO = 3;

    localparam int TIMER_W = 16;

    function automatic logic [2:0] ir_opcode(input logic [15:0] word);
        return word[OPCODE_HI:OPCODE_LO];
    endfunction

    // Saturating increment so the retire counter never rolls over.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_exec_timer.sv
// Loadable up-counter with a terminal-count flag; shared by the memory
// wait and the execute-timeout paths of the fetch sequencer.
module exec_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == limit);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch / issue sequencer sitting above the datapath controller:
// fetches at pc, latches ir, pulses exec_start and waits for the handshake.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int MEM_LAT      = 1,
    parameter int EXEC_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       ir,
    output logic              exec_start,
    input  logic              exec_waiting,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              halted,
    output logic              illegal,
    output logic              error
);

    localparam logic [TIMER_W-1:0] WAIT_LIM = TIMER_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam logic [TIMER_W-1:0] EXEC_LIM = TIMER_W'(EXEC_TIMEOUT - 1);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;
    logic              error_q, error_d;
    logic              mem_rd_q, mem_rd_d;
    logic              start_q, start_d;

    logic               tmr_clr;
    logic               tmr_en;
    logic [TIMER_W-1:0] tmr_limit;
    logic               tmr_tc;

    exec_timer #(.W(TIMER_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    // Next-state and datapath update logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        error_d   = error_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        tmr_limit = (state_q == WAIT_MEM) ? WAIT_LIM : EXEC_LIM;

        case (state_q)
            IDLE: begin
                if (run && !halted_q && !error_q) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                tmr_clr = 1'b1;
                if (MEM_LAT > 1) begin
                    state_d = WAIT_MEM;
                end else begin
                    state_d = LOAD_IR;
                end
            end
            WAIT_MEM: begin
                if (tmr_tc) begin
                    state_d = LOAD_IR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            LOAD_IR: begin
                ir_d    = mem_rdata;
                state_d = DECODE;
            end
            DECODE: begin
                case (ir_opcode(ir_q))
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = IDLE;
                    end
                    OP_ALU, OP_MOV: begin
                        state_d = START;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ADVANCE;
                    end
                endcase
            end
            START: begin
                tmr_clr = 1'b1;
                state_d = EXEC_ACK;
            end
            EXEC_ACK: begin
                if (!exec_waiting) begin
                    tmr_clr = 1'b1;
                    state_d = EXEC_DONE;
                end else if (tmr_tc) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            EXEC_DONE: begin
                if (exec_waiting) begin
                    state_d = RETIRE;
                end else if (tmr_tc) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RETIRE: begin
                cnt_d   = sat_inc16(cnt_q);
                state_d = ADVANCE;
            end
            ADVANCE: begin
                pc_d = pc_q + ADDR_W'(1);
                if (run) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are decoded from the upcoming state so they leave a flop.
        mem_rd_d = (state_d == FETCH);
        start_d  = (state_d == START);
    end

    // State, architectural registers and registered strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ir_q      <= 16'h0000;
            cnt_q     <= 16'h0000;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            error_q   <= 1'b0;
            mem_rd_q  <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            error_q   <= error_d;
            mem_rd_q  <= mem_rd_d;
            start_q   <= start_d;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign exec_start  = start_q;
    assign instr_count = cnt_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign error       = error_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: three sequencer instances (default, MEM_LAT=3, ADDR_W=2)
// with a shared instruction memory and a simple controller handshake model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run0 = 1'b0, run1 = 1'b0, run2 = 1'b0;
    logic hang = 1'b0;

    logic [15:0] mem [0:255];

    logic        mem_rd0, exec_start0, halted0, illegal0, error0;
    logic [7:0]  mem_addr0, pc0;
    logic [15:0] ir0, instr_count0, rdata0;

    logic        mem_rd1, exec_start1, halted1, illegal1, error1;
    logic [7:0]  mem_addr1, pc1;
    logic [15:0] ir1, instr_count1;
    logic [15:0] pipe1 [0:2];

    logic        mem_rd2, exec_start2, halted2, illegal2, error2;
    logic [1:0]  mem_addr2, pc2;
    logic [15:0] ir2, instr_count2, rdata2;

    logic [2:0]  waiting_v;
    logic [1:0]  busy [0:2];
    logic [2:0]  start_v;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(8), .MEM_LAT(1), .EXEC_TIMEOUT(15)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .run(run0), .mem_rd(mem_rd0), .mem_addr(mem_addr0),
        .mem_rdata(rdata0), .ir(ir0), .exec_start(exec_start0), .exec_waiting(waiting_v[0]),
        .pc(pc0), .instr_count(instr_count0), .halted(halted0), .illegal(illegal0), .error(error0)
    );

    fetch_sequencer #(.ADDR_W(8), .MEM_LAT(3), .EXEC_TIMEOUT(15)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .run(run1), .mem_rd(mem_rd1), .mem_addr(mem_addr1),
        .mem_rdata(pipe1[2]), .ir(ir1), .exec_start(exec_start1), .exec_waiting(waiting_v[1]),
        .pc(pc1), .instr_count(instr_count1), .halted(halted1), .illegal(illegal1), .error(error1)
    );

    fetch_sequencer #(.ADDR_W(2), .MEM_LAT(1), .EXEC_TIMEOUT(15)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .run(run2), .mem_rd(mem_rd2), .mem_addr(mem_addr2),
        .mem_rdata(rdata2), .ir(ir2), .exec_start(exec_start2), .exec_waiting(waiting_v[2]),
        .pc(pc2), .instr_count(instr_count2), .halted(halted2), .illegal(illegal2), .error(error2)
    );

    assign start_v = {exec_start2, exec_start1, exec_start0};

    // Instruction memory: data appears MEM_LAT cycles after the read strobe.
    always @(posedge clk) begin
        rdata0   <= mem_rd0 ? mem[mem_addr0] : 16'h0000;
        pipe1[0] <= mem_rd1 ? mem[mem_addr1] : 16'h0000;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
        rdata2   <= mem_rd2 ? mem[{6'd0, mem_addr2}] : 16'h0000;
    end

    // Controller model: waiting drops 1 cycle after start, returns 2 cycles later.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                waiting_v[k] <= 1'b1;
                busy[k]      <= 2'd0;
            end else if (start_v[k] && !(k == 0 && hang)) begin
                waiting_v[k] <= 1'b0;
                busy[k]      <= 2'd2;
            end else if (busy[k] != 2'd0) begin
                busy[k] <= busy[k] - 2'd1;
                if (busy[k] == 2'd1) waiting_v[k] <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run0 = 1'b0; run1 = 1'b0; run2 = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    endtask

    initial begin
        int n_st, st_cyc, n_rd;
        int idx;
        logic [1:0] pcs [0:4];
        logic [1:0] exp_pc [0:4];

        // Reset values
        clear_mem();
        rst_n = 1'b0;
        step(2);
        check("rst_pc", pc0, 0);
        check("rst_ir", ir0, 0);
        check("rst_count", instr_count0, 0);
        check("rst_flags", {halted0, illegal0, error0}, 0);
        check("rst_strobes", {mem_rd0, exec_start0}, 0);

        // MOV then HALT, MEM_LAT=1
        mem[0] = 16'hD105;
        mem[1] = 16'hE000;
        do_reset();
        run0 = 1'b1;
        n_st = 0; st_cyc = 0; n_rd = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (exec_start0) begin
                n_st++;
                st_cyc = i;
                check("t1_ir_at_start", ir0, 16'hD105);
            end
            if (mem_rd0) n_rd++;
        end
        check("t1_starts", n_st, 1);
        check("t1_start_cycle", st_cyc, 4);
        check("t1_fetches", n_rd, 2);
        check("t1_count", instr_count0, 1);
        check("t1_pc", pc0, 1);
        check("t1_halted", halted0, 1);
        check("t1_illegal", illegal0, 0);

        // Same program, MEM_LAT=3
        do_reset();
        run1 = 1'b1;
        n_st = 0; st_cyc = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (exec_start1) begin
                n_st++;
                st_cyc = i;
                check("t2_ir_at_start", ir1, 16'hD105);
            end
        end
        check("t2_starts", n_st, 1);
        check("t2_start_cycle", st_cyc, 6);
        check("t2_count", instr_count1, 1);
        check("t2_pc", pc1, 1);
        check("t2_halted", halted1, 1);

        // Illegal opcode skipped, then ALU, then HALT
        clear_mem();
        mem[0] = 16'h2000;
        mem[1] = 16'hA000;
        mem[2] = 16'hE000;
        do_reset();
        run0 = 1'b1;
        n_st = 0; st_cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (exec_start0) begin
                n_st++;
                if (st_cyc == 0) st_cyc = i;
            end
            if (i == 4) check("t3_illegal_early", illegal0, 1);
        end
        check("t3_starts", n_st, 1);
        check("t3_start_cycle", st_cyc, 8);
        check("t3_illegal", illegal0, 1);
        check("t3_count", instr_count0, 1);
        check("t3_pc", pc0, 2);
        check("t3_halted", halted0, 1);

        // Hung controller -> timeout
        clear_mem();
        mem[0] = 16'hD105;
        hang = 1'b1;
        do_reset();
        run0 = 1'b1;
        n_rd = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (mem_rd0) n_rd++;
            if (i == 18) check("t4_error_not_yet", error0, 0);
            if (i == 20) check("t4_error_set", error0, 1);
        end
        check("t4_fetches", n_rd, 1);
        check("t4_pc", pc0, 0);
        check("t4_count", instr_count0, 0);
        check("t4_start_idle", exec_start0, 0);
        hang = 1'b0;

        // ADDR_W=2 wrap with run held high
        for (int a = 0; a < 4; a++) mem[a] = 16'hA000;
        exp_pc[0] = 2'd0; exp_pc[1] = 2'd1; exp_pc[2] = 2'd2; exp_pc[3] = 2'd3; exp_pc[4] = 2'd0;
        do_reset();
        run2 = 1'b1;
        idx = 0;
        for (int i = 1; i <= 50; i++) begin
            step(1);
            if (mem_rd2 && idx < 5) begin
                pcs[idx] = pc2;
                idx++;
            end
        end
        check("t5_fetches", idx, 5);
        for (int k = 0; k < 5; k++) check($sformatf("t5_pc%0d", k), pcs[k], exp_pc[k]);
        check("t5_count", instr_count2, 5);
        check("t5_pc_end", pc2, 1);

        // run dropped during EXEC_DONE
        do_reset();
        run0 = 1'b1;
        step(6);
        run0 = 1'b0;
        step(4);
        check("t6_count", instr_count0, 1);
        check("t6_pc", pc0, 1);
        n_rd = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (mem_rd0) n_rd++;
        end
        check("t6_no_fetch", n_rd, 0);
        check("t6_pc_hold", pc0, 1);

        // Reset during EXEC_DONE of the second instruction
        do_reset();
        run0 = 1'b1;
        step(15);
        check("t7_pre_pc", pc0, 1);
        check("t7_pre_count", instr_count0, 1);
        rst_n = 1'b0;
        step(1);
        check("t7_pc", pc0, 0);
        check("t7_ir", ir0, 0);
        check("t7_count", instr_count0, 0);
        check("t7_flags", {halted0, illegal0, error0}, 0);
        check("t7_strobes", {mem_rd0, exec_start0}, 0);
        rst_n = 1'b1;
        run0 = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
